// File: rtl/cpu_uart_pkg.sv
// Shared constants for the UART-loaded 16-bit CPU: baud timing, opcodes,
// loader select codes and the instruction word layout.
package cpu_uart_pkg;

    localparam int DEF_CLK_FREQ = 100_000_000;
    localparam int DEF_BAUD     = 9600;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    localparam int CLKS_PER_BIT = clks_per_bit(DEF_CLK_FREQ, DEF_BAUD);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_OUT  = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_BNZ  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] SEL_RUN  = 2'd0;
    localparam logic [1:0] SEL_IMEM = 2'd1;
    localparam logic [1:0] SEL_DMEM = 2'd2;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
    } instr_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver: synchronised input, start confirmed at mid-bit,
// one-clk valid pulse on a good stop bit, frame_err pulse on a bad one.
module uart_rx import cpu_uart_pkg::*; #(
    parameter int CLKS_PER_BIT = cpu_uart_pkg::CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);

    rx_state_t   state;
    logic        rx_m, rx_s, rx_d;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  sr;

    assign data = sr;
    assign busy = (state != RX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {rx_m, rx_s, rx_d} <= 3'b111;
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            sr        <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            rx_d      <= rx_s;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (rx_d && !rx_s) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? RX_IDLE : RX_DATA;
                    end else cnt <= cnt + 16'd1;
                end
                RX_DATA: begin
                    if (cnt == FULL) begin
                        cnt <= '0;
                        sr  <= {rx_s, sr[7:1]};
                        if (bit_idx == 3'd7) state <= RX_STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else cnt <= cnt + 16'd1;
                end
                default: begin
                    if (cnt == FULL) begin
                        state     <= RX_IDLE;
                        valid     <= rx_s;
                        frame_err <= !rx_s;
                    end else cnt <= cnt + 16'd1;
                end
            endcase
        end
    end

endmodule

// File: rtl/cpu_uart_system.sv
// Tiny 16-bit CPU whose IMEM/DMEM are loaded as 2-byte words over UART
// and whose OUT instruction transmits a register over UART.
module cpu_uart_system import cpu_uart_pkg::*; #(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD,
    parameter int MEM_AW   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxData,
    input  logic [1:0] UartSel,
    output logic       TxData
);

    localparam int          CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int          DEPTH = 1 << MEM_AW;
    localparam logic [15:0] FULL  = 16'(CPB - 1);

    logic [15:0] imem [DEPTH];
    logic [15:0] dmem [DEPTH];
    logic [15:0] regs [16];

    logic [MEM_AW-1:0] pc, iptr, dptr;
    logic              halted, out_started;

    logic [7:0] rx_data;
    logic       rx_valid, rx_ferr, rx_busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
        .clk(clk), .rst_n(reset), .rx(RxData),
        .data(rx_data), .valid(rx_valid), .frame_err(rx_ferr), .busy(rx_busy)
    );

    // Word assembly: high byte first; a framing error drops any half word.
    logic        byte_tgl, word_done;
    logic [7:0]  hi_byte;
    logic [15:0] word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_tgl  <= 1'b0;
            hi_byte   <= '0;
            word      <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (rx_ferr) byte_tgl <= 1'b0;
            else if (rx_valid) begin
                if (!byte_tgl) begin
                    hi_byte  <= rx_data;
                    byte_tgl <= 1'b1;
                end else begin
                    word      <= {hi_byte, rx_data};
                    word_done <= 1'b1;
                    byte_tgl  <= 1'b0;
                end
            end
        end
    end

    logic load_imem, load_dmem;
    assign load_imem = word_done && (UartSel == SEL_IMEM);
    assign load_dmem = word_done && (UartSel == SEL_DMEM);

    instr_t            ins;
    logic [7:0]        imm;
    logic [MEM_AW-1:0] maddr;
    logic              run_en, exec, st_we, tx_start, tx_active;

    assign ins      = instr_t'(imem[pc]);
    assign imm      = {ins.rs, ins.rt};
    assign maddr    = imm[MEM_AW-1:0];
    assign run_en   = (UartSel == SEL_RUN) && !rx_busy;
    assign exec     = run_en && !halted;
    assign st_we    = exec && (ins.op == OP_ST);
    assign tx_start = exec && (ins.op == OP_OUT) && !out_started;

    always_ff @(posedge clk) begin
        if (load_imem) imem[iptr] <= word;
    end

    always_ff @(posedge clk) begin
        if (load_dmem) dmem[dptr] <= word;
        else if (st_we) dmem[maddr] <= regs[ins.rd];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iptr <= '0;
            dptr <= '0;
        end else begin
            if (load_imem) iptr <= iptr + 1'b1;
            if (load_dmem) dptr <= dptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= '0;
            halted      <= 1'b0;
            out_started <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (!run_en) begin
            pc          <= '0;
            out_started <= 1'b0;
            if (load_imem || load_dmem) halted <= 1'b0;
        end else if (!halted) begin
            case (ins.op)
                OP_ADD: begin regs[ins.rd] <= regs[ins.rs] + regs[ins.rt]; pc <= pc + 1'b1; end
                OP_LD:  begin regs[ins.rd] <= dmem[maddr];                 pc <= pc + 1'b1; end
                OP_LDI: begin regs[ins.rd] <= {8'h00, imm};                pc <= pc + 1'b1; end
                OP_SUB: begin regs[ins.rd] <= regs[ins.rs] - regs[ins.rt]; pc <= pc + 1'b1; end
                OP_OUT: begin
                    // Hold PC until both frames, including stop bits, have left.
                    if (!out_started) out_started <= 1'b1;
                    else if (!tx_active) begin
                        out_started <= 1'b0;
                        pc          <= pc + 1'b1;
                    end
                end
                OP_BNZ:  pc <= (regs[ins.rd] != '0) ? maddr : pc + 1'b1;
                OP_HALT: halted <= 1'b1;
                default: pc <= pc + 1'b1;
            endcase
        end
    end

    // TX: 10-bit frame shifter; the low byte waits in tx_pend_byte.
    logic [9:0]  tx_sr;
    logic [7:0]  tx_pend_byte;
    logic        tx_pend;
    logic [3:0]  tx_bits;
    logic [15:0] tx_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_sr        <= '1;
            tx_pend_byte <= '0;
            tx_pend      <= 1'b0;
            tx_active    <= 1'b0;
            tx_bits      <= '0;
            tx_cnt       <= '0;
            TxData       <= 1'b1;
        end else begin
            TxData <= !tx_active || tx_sr[0];
            if (tx_start) begin
                tx_sr        <= {1'b1, regs[ins.rd][15:8], 1'b0};
                tx_pend_byte <= regs[ins.rd][7:0];
                tx_pend      <= 1'b1;
                tx_active    <= 1'b1;
                tx_bits      <= '0;
                tx_cnt       <= '0;
            end else if (tx_active) begin
                if (tx_cnt == FULL) begin
                    tx_cnt <= '0;
                    if (tx_bits == 4'd9) begin
                        tx_bits <= '0;
                        if (tx_pend) begin
                            tx_sr   <= {1'b1, tx_pend_byte, 1'b0};
                            tx_pend <= 1'b0;
                        end else tx_active <= 1'b0;
                    end else begin
                        tx_sr   <= {1'b1, tx_sr[9:1]};
                        tx_bits <= tx_bits + 4'd1;
                    end
                end else tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_uart_system.sv
// Bench for cpu_uart_system: UART word loads, program runs checked against an
// instruction-level model, framing-error recovery and PC/pointer wrap.
module tb_cpu_uart_system;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       RxData = 1'b1;
    logic [1:0] UartSel = 2'd3;
    logic       TxData;

    always #5 clk = ~clk;

    cpu_uart_system #(.CLK_FREQ(800_000), .BAUD(100_000), .MEM_AW(8)) dut (
        .clk(clk), .reset(reset), .RxData(RxData), .UartSel(UartSel), .TxData(TxData)
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] m_imem [256];
    logic [15:0] m_dmem [256];
    logic [15:0] m_regs [16];
    logic [7:0]  m_pc;
    int          m_iptr, m_dptr;
    logic [7:0]  exp_out [$];
    logic [7:0]  tx_q [$];
    bit          quiet = 1'b0;
    bit          tx_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Decode whatever the DUT transmits into tx_q.
    initial begin
        logic [7:0] b;
        wait (tx_en);
        forever begin
            @(negedge clk);
            if (TxData === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = TxData;
                end
                repeat (CPB) @(negedge clk);
                check("tx_stop_bit", {31'd0, TxData}, 32'd1);
                tx_q.push_back(b);
            end
        end
    end

    // Whenever no transmission is expected the line must idle high.
    initial forever begin
        @(negedge clk);
        if (quiet) check("tx_idle", {31'd0, TxData}, 32'd1);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) RxData = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxData = b[i];
            repeat (CPB) @(negedge clk);
        end
        RxData = stop;
        repeat (CPB) @(negedge clk);
        RxData = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
        repeat (4) @(negedge clk);
        if (UartSel == 2'd1) begin m_imem[m_iptr] = w; m_iptr = (m_iptr + 1) % 256; end
        if (UartSel == 2'd2) begin m_dmem[m_dptr] = w; m_dptr = (m_dptr + 1) % 256; end
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txdata", {31'd0, TxData}, 32'd1);
        check("rst_pc", {24'd0, dut.pc}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
        m_iptr = 0;
        m_dptr = 0;
    endtask

    // Instruction-set interpreter: runs from PC 0 until HALT.
    task automatic run_model();
        logic [15:0] w;
        logic [3:0]  rd, rs, rt;
        logic [7:0]  im;
        m_pc = 8'd0;
        exp_out.delete();
        for (int s = 0; s < 5000; s++) begin
            w = m_imem[m_pc];
            rd = w[11:8]; rs = w[7:4]; rt = w[3:0]; im = w[7:0];
            if (w[15:12] == 4'hF) break;
            case (w[15:12])
                4'h0: m_regs[rd] = m_regs[rs] + m_regs[rt];
                4'h1: m_regs[rd] = m_dmem[im];
                4'h2: m_regs[rd] = {8'h00, im};
                4'h3: m_regs[rd] = m_regs[rs] - m_regs[rt];
                4'h4: begin exp_out.push_back(m_regs[rd][15:8]); exp_out.push_back(m_regs[rd][7:0]); end
                4'h5: m_dmem[im] = m_regs[rd];
                default: ;
            endcase
            if (w[15:12] == 4'h6 && m_regs[rd] != 16'h0) m_pc = im;
            else m_pc = m_pc + 8'd1;
        end
    endtask

    task automatic run_and_compare(input string tag);
        quiet = 1'b0;
        tx_q.delete();
        run_model();
        @(negedge clk) UartSel = 2'd0;
        for (int c = 0; c < 3000 && tx_q.size() < exp_out.size(); c++) @(negedge clk);
        repeat (4 * CPB) @(negedge clk);
        check({tag, "_tx_count"}, tx_q.size(), exp_out.size());
        for (int i = 0; i < exp_out.size() && i < tx_q.size(); i++)
            check({tag, "_tx_byte"}, {24'd0, tx_q[i]}, {24'd0, exp_out[i]});
        for (int i = 0; i < 16; i++)
            check({tag, "_reg"}, {16'd0, dut.regs[i]}, {16'd0, m_regs[i]});
        check({tag, "_halt_pc"}, {24'd0, dut.pc}, {24'd0, m_pc});
        quiet = 1'b1;
        repeat (20 * CPB) @(negedge clk);
        check({tag, "_pc_stays"}, {24'd0, dut.pc}, {24'd0, m_pc});
    endtask

    logic [15:0] prog_run [5] = '{16'h2005, 16'h1101, 16'h0201, 16'h4200, 16'hF000};
    logic [15:0] prog_imem [4] = '{16'h20F2, 16'h1104, 16'h0113, 16'h0024};
    logic [15:0] wrap_prog [9] = '{16'h6708, 16'h2103, 16'h2301, 16'h2400, 16'h0443,
                                   16'h3113, 16'h6104, 16'h63FE, 16'hF000};

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txdata", {31'd0, TxData}, 32'd1);
        check("rst_pc", {24'd0, dut.pc}, 32'd0);
        check("rst_iptr", {24'd0, dut.iptr}, 32'd0);
        check("rst_dptr", {24'd0, dut.dptr}, 32'd0);
        check("rst_reg0", {16'd0, dut.regs[0]}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
        m_iptr = 0; m_dptr = 0;
        tx_en = 1'b1;
        quiet = 1'b1;

        // IMEM load
        UartSel = 2'd1;
        foreach (prog_imem[i]) send_word(prog_imem[i]);
        for (int i = 0; i < 4; i++) check("imem_load", {16'd0, dut.imem[i]}, {16'd0, m_imem[i]});
        check("imem_word2", {16'd0, dut.imem[2]}, 32'h0113);
        check("iptr_after_4", {24'd0, dut.iptr}, 32'd4);

        // DMEM load 100..900
        UartSel = 2'd2;
        for (int i = 1; i <= 9; i++) send_word(16'(i * 100));
        for (int i = 0; i < 9; i++) check("dmem_load", {16'd0, dut.dmem[i]}, {16'd0, m_dmem[i]});
        check("dmem_word8", {16'd0, dut.dmem[8]}, 32'h0384);
        check("dptr_after_9", {24'd0, dut.dptr}, 32'd9);

        // Run: LDI/LD/ADD/OUT/HALT using DMEM[1]=0x00C8 from the load above
        UartSel = 2'd3;
        do_reset();
        UartSel = 2'd1;
        foreach (prog_run[i]) send_word(prog_run[i]);
        run_and_compare("run");
        check("run_r2_lit", {16'd0, dut.regs[2]}, 32'h00CD);
        check("run_tx_n_lit", tx_q.size(), 32'd2);
        if (tx_q.size() == 2) begin
            check("run_tx0_lit", {24'd0, tx_q[0]}, 32'h00);
            check("run_tx1_lit", {24'd0, tx_q[1]}, 32'hCD);
        end

        // Framing error: good byte, bad-stop byte, then a full good word
        UartSel = 2'd3;
        do_reset();
        UartSel = 2'd1;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        repeat (CPB) @(negedge clk);
        send_word(16'hABCD);
        check("ferr_imem0", {16'd0, dut.imem[0]}, {16'd0, m_imem[0]});
        check("ferr_imem0_lit", {16'd0, dut.imem[0]}, 32'hABCD);
        check("ferr_iptr", {24'd0, dut.iptr}, 32'd1);

        // BNZ loop plus PC wrap: fill all 256 IMEM words so iptr wraps too
        UartSel = 2'd3;
        do_reset();
        UartSel = 2'd1;
        for (int i = 0; i < 256; i++) begin
            if (i < 9)        send_word(wrap_prog[i]);
            else if (i == 254) send_word(16'h2655);
            else if (i == 255) send_word(16'h0773);
            else              send_word(16'h7000);
        end
        check("iptr_wrap", {24'd0, dut.iptr}, 32'd0);
        run_and_compare("wrap");
        check("wrap_r4_lit", {16'd0, dut.regs[4]}, 32'd3);
        check("wrap_r1_lit", {16'd0, dut.regs[1]}, 32'd0);
        check("wrap_r6_lit", {16'd0, dut.regs[6]}, 32'h55);
        check("wrap_r7_lit", {16'd0, dut.regs[7]}, 32'd1);
        check("wrap_pc_lit", {24'd0, dut.pc}, 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
